flag_cond_unit: RTL and testbench

Condition-code consumer for the ALU's 4-bit `Flags` output. It holds the architectural NZCV flags register, written by the substractor/adder path. It evaluates 4-bit branch/predicate condition codes against those flags through a valid/ready pipeline stage with backpressure. It optionally keeps a small saved-flags stack for interrupt entry/exit. It sits between the ALU execute stage and branch/predication logic.

---
 rtl/flag_cond_unit.sv | 171 +++++++++++++++++
 tb/tb_flag_cond_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flag_cond_unit.sv
// NZCV flags register with condition-code evaluation through a one-deep valid/ready result stage.
// Optional saved-flags LIFO for interrupt entry/exit is built only when FLAG_STACK_EN is defined.
`timescale 1ns/1ps

module flag_cond_unit #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] FlagsIn,
    input  logic       FlagsWe,
    input  logic [3:0] Cond,
    input  logic       CondValid,
    output logic       CondReady,
    output logic       Taken,
    output logic       TakenValid,
    input  logic       TakenReady,
    input  logic       Push,
    input  logic       Pop,
    output logic [3:0] Flags,
    output logic       StackFull,
    output logic       StackEmpty,
    output logic       StackErr
);

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_e;

    logic [3:0] flags_q;
    logic [3:0] flags_next;
    logic [3:0] eff_flags;
    logic       flag_n, flag_z, flag_c, flag_v;
    logic       cond_hit;
    logic       accept;

    // A same-cycle write is forwarded; a same-cycle pop is not.
    assign eff_flags = FlagsWe ? FlagsIn : flags_q;
    assign {flag_n, flag_z, flag_c, flag_v} = eff_flags;

    // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cond_hit = 1'b0;
        case (cond_e'(Cond))
            COND_EQ: cond_hit = flag_z;
            COND_NE: cond_hit = !flag_z;
            COND_CS: cond_hit = flag_c;
            COND_CC: cond_hit = !flag_c;
            COND_MI: cond_hit = flag_n;
            COND_PL: cond_hit = !flag_n;
            COND_VS: cond_hit = flag_v;
            COND_VC: cond_hit = !flag_v;
            COND_HI: cond_hit = flag_c && !flag_z;
            COND_LS: cond_hit = !flag_c || flag_z;
            COND_GE: cond_hit = (flag_n == flag_v);
            COND_LT: cond_hit = (flag_n != flag_v);
            COND_GT: cond_hit = !flag_z && (flag_n == flag_v);
            COND_LE: cond_hit = flag_z || (flag_n != flag_v);
            COND_AL: cond_hit = 1'b1;
            COND_NV: cond_hit = 1'b0;
            default: cond_hit = 1'b0;
        endcase
    end

    assign CondReady = !TakenValid || TakenReady;
    assign accept    = CondValid && CondReady;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Taken      <= 1'b0;
            TakenValid <= 1'b0;
        end else if (accept) begin
            Taken      <= cond_hit;
            TakenValid <= 1'b1;
        end else if (TakenReady) begin
            TakenValid <= 1'b0;
        end
    end

`ifdef FLAG_STACK_EN
    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = $clog2(DEPTH);

    logic [PTR_W-1:0] sp;
    logic [3:0]       stack_mem [DEPTH];
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] top_idx;
    logic             stack_full;
    logic             stack_empty;
    logic             push_ok;
    logic             pop_ok;
    logic             stack_bad;
    logic             err_q;

    assign stack_full  = (sp == PTR_W'(DEPTH));
    assign stack_empty = (sp == '0);
    assign push_idx    = IDX_W'(sp);
    assign top_idx     = IDX_W'(sp - 1'b1);

    // Misuse is ignored outright: no pointer movement, no flags restore.
    assign push_ok   = Push && !Pop && !stack_full;
    assign pop_ok    = Pop && !Push && !stack_empty;
    assign stack_bad = (Push && Pop) || (Push && stack_full) || (Pop && stack_empty);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp    <= '0;
            err_q <= 1'b0;
        end else begin
            if (push_ok) begin
                sp <= sp + 1'b1;
            end else if (pop_ok) begin
                sp <= sp - 1'b1;
            end
            if (stack_bad) begin
                err_q <= 1'b1;
            end
        end
    end

    // NOTE: the stack storage is deliberately not reset; the pointer alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            stack_mem[push_idx] <= flags_q;
        end
    end

    always_comb begin
        flags_next = flags_q;
        if (pop_ok) begin
            flags_next = stack_mem[top_idx];
        end else if (FlagsWe) begin
            flags_next = FlagsIn;
        end
    end

    assign StackFull  = stack_full;
    assign StackEmpty = stack_empty;
    assign StackErr   = err_q;
`else
    logic unused_stack_ctl;

    assign unused_stack_ctl = Push ^ Pop;

    always_comb begin
        flags_next = flags_q;
        if (FlagsWe) begin
            flags_next = FlagsIn;
        end
    end

    assign StackFull  = 1'b0;
    assign StackEmpty = 1'b1;
    assign StackErr   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_next;
        end
    end

    assign Flags = flags_q;

endmodule

// File: tb/tb_flag_cond_unit.sv
// Scoreboard bench for flag_cond_unit: a queue-based reference model predicts results,
// flags and stack status; a negedge monitor compares. Stack expectations follow FLAG_STACK_EN.
`timescale 1ns/1ps

module tb_flag_cond_unit;

    localparam int DEPTH = 4;
`ifdef FLAG_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] FlagsIn;
    logic       FlagsWe;
    logic [3:0] Cond;
    logic       CondValid;
    logic       CondReady;
    logic       Taken;
    logic       TakenValid;
    logic       TakenReady;
    logic       Push;
    logic       Pop;
    logic [3:0] Flags;
    logic       StackFull;
    logic       StackEmpty;
    logic       StackErr;

    flag_cond_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .FlagsIn(FlagsIn), .FlagsWe(FlagsWe),
        .Cond(Cond), .CondValid(CondValid), .CondReady(CondReady),
        .Taken(Taken), .TakenValid(TakenValid), .TakenReady(TakenReady),
        .Push(Push), .Pop(Pop), .Flags(Flags),
        .StackFull(StackFull), .StackEmpty(StackEmpty), .StackErr(StackErr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [3:0] m_flags = 4'b0000;
    logic       m_tv    = 1'b0;
    logic       m_err   = 1'b0;
    logic [3:0] m_stack[$];
    logic       exp_q[$];
    logic       mon_en  = 1'b0;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Conditions come in complementary pairs; odd codes invert the even predicate.
    function automatic logic cond_ref(input logic [3:0] code, input logic [3:0] f);
        bit n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (code >> 1)
            0: base = z;
            1: base = c;
            2: base = n;
            3: base = v;
            4: base = c && !z;
            5: base = (n == v);
            6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return code[0] ? !base : base;
    endfunction

    task automatic model_step(input logic cv, input logic [3:0] cd, input logic rdy,
                              input logic we, input logic [3:0] fin,
                              input logic ps, input logic pp);
        logic       acc;
        logic [3:0] eff;
        logic       popped;
        logic [3:0] pv;
        popped = 1'b0;
        pv     = 4'b0000;
        acc = cv && (!m_tv || rdy);
        eff = we ? fin : m_flags;
        if (acc) begin
            exp_q.push_back(cond_ref(cd, eff));
            m_tv = 1'b1;
        end else if (rdy) begin
            m_tv = 1'b0;
        end
        if (STK) begin
            if (ps && pp) m_err = 1'b1;
            else if (ps) begin
                if (m_stack.size() == DEPTH) m_err = 1'b1;
                else m_stack.push_back(m_flags);
            end else if (pp) begin
                if (m_stack.size() == 0) m_err = 1'b1;
                else begin
                    pv = m_stack.pop_back();
                    popped = 1'b1;
                end
            end
        end
        if (popped) m_flags = pv;
        else if (we) m_flags = fin;
    endtask

    // Called just after a rising edge; applies inputs for one cycle, then advances the model.
    task automatic drive(input logic cv, input logic [3:0] cd, input logic rdy,
                         input logic we, input logic [3:0] fin,
                         input logic ps, input logic pp);
        CondValid = cv; Cond = cd; TakenReady = rdy;
        FlagsWe = we; FlagsIn = fin; Push = ps; Pop = pp;
        @(posedge clk);
        #1;
        model_step(cv, cd, rdy, we, fin, ps, pp);
    endtask

    task automatic set_idle();
        CondValid = 1'b0; Cond = 4'h0; TakenReady = 1'b1;
        FlagsWe = 1'b0; FlagsIn = 4'h0; Push = 1'b0; Pop = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_flags"}, Flags, 4'b0000);
        check({tag, "_tvalid"}, TakenValid, 1'b0);
        check({tag, "_taken"}, Taken, 1'b0);
        check({tag, "_cready"}, CondReady, 1'b1);
        check({tag, "_sempty"}, StackEmpty, 1'b1);
        check({tag, "_sfull"}, StackFull, 1'b0);
        check({tag, "_serr"}, StackErr, 1'b0);
    endtask

    // Asynchronous reset asserted between edges; outputs must drop before any clock.
    task automatic reset_mid();
        mon_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        set_idle();
        m_flags = 4'b0000; m_tv = 1'b0; m_err = 1'b0;
        m_stack.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("flags", Flags, m_flags);
            check("tvalid", TakenValid, m_tv);
            check("cready", CondReady, !m_tv || TakenReady);
            check("sfull", StackFull, m_stack.size() == DEPTH);
            check("sempty", StackEmpty, m_stack.size() == 0);
            check("serr", StackErr, m_err);
            if (m_tv) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard: result valid with no expected entry at %0t", $time);
                end else begin
                    check("taken", Taken, exp_q[0]);
                    if (TakenReady) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [3:0] seq_cond [6];
        logic       seq_exp  [6];
        seq_cond = '{4'hA, 4'h3, 4'h1, 4'h0, 4'hE, 4'hF};
        seq_exp  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

        rst = 1'b1;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst_init");
        rst = 1'b0;
        mon_en = 1'b1;

        // Forwarded write with LT in the same cycle (10-30 flags)
        drive(1, 4'hB, 1, 1, 4'b1000, 0, 0);
        check("fwd_taken", Taken, 1'b1);
        check("fwd_tvalid", TakenValid, 1'b1);
        check("fwd_flags", Flags, 4'b1000);

        // Back-to-back GE, CC, NE, EQ, AL, NV
        for (int i = 0; i < 6; i++) begin
            drive(1, seq_cond[i], 1, 0, 4'h0, 0, 0);
            check($sformatf("seq%0d_taken", i), Taken, seq_exp[i]);
        end

        // Backpressure: LT held while EQ waits
        drive(1, 4'hB, 1, 0, 4'h0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'h0, 0, 0, 4'h0, 0, 0);
            check("bp_cready", CondReady, 1'b0);
            check("bp_taken", Taken, 1'b1);
        end
        drive(1, 4'h0, 1, 0, 4'h0, 0, 0);
        check("bp_eq_taken", Taken, 1'b0);
        check("bp_eq_tvalid", TakenValid, 1'b1);
        drive(0, 4'h0, 1, 0, 4'h0, 0, 0);

        // Push 0100, overwrite with 0011, pop restores
        drive(0, 4'h0, 1, 1, 4'b0100, 0, 0);
        drive(0, 4'h0, 1, 0, 4'h0, 1, 0);
        drive(0, 4'h0, 1, 1, 4'b0011, 0, 0);
        drive(0, 4'h0, 1, 0, 4'h0, 0, 1);
        check("pop_flags", Flags, STK ? 4'b0100 : 4'b0011);
        check("pop_empty", StackEmpty, 1'b1);

        // Fill to DEPTH, then overflow
        for (int i = 0; i < 5; i++) begin
            drive(0, 4'h0, 1, 0, 4'h0, 1, 0);
            if (i == 3) check("fill_full", StackFull, STK);
            if (i == 4) begin
                check("ovf_err", StackErr, STK);
                check("ovf_full", StackFull, STK);
            end
        end

        // Reset with a pending result and a non-empty stack
        drive(1, 4'hE, 0, 0, 4'h0, 0, 0);
        check("pre_rst_tvalid", TakenValid, 1'b1);
        check("pre_rst_taken", Taken, 1'b1);
        reset_mid();

        // Pop on empty must not block the write
        drive(0, 4'h0, 1, 1, 4'b0110, 0, 1);
        check("pop_empty_flags", Flags, 4'b0110);
        check("pop_empty_err", StackErr, STK);
        reset_mid();

        // Simultaneous push and pop is rejected
        drive(0, 4'h0, 1, 1, 4'b1010, 0, 0);
        drive(0, 4'h0, 1, 0, 4'h0, 1, 0);
        drive(0, 4'h0, 1, 0, 4'h0, 1, 1);
        check("pp_err", StackErr, STK);
        check("pp_empty", StackEmpty, !STK);
        drive(0, 4'h0, 1, 0, 4'h0, 0, 1);
        check("pp_pop_flags", Flags, 4'b1010);
        check("pp_pop_empty", StackEmpty, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic       cv, rdy, we, ps, pp;
            logic [3:0] cd, fin;
            cv  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 9) < 7);
            we  = ($urandom_range(0, 9) < 3);
            ps  = ($urandom_range(0, 9) == 0);
            pp  = ($urandom_range(0, 9) == 0);
            cd  = 4'($urandom);
            fin = 4'($urandom);
            if (pp && !ps && m_stack.size() != 0) we = 1'b0;
            if (i == 200) reset_mid();
            drive(cv, cd, rdy, we, fin, ps, pp);
        end

        // Drain any pending result
        for (int i = 0; i < 3; i++) drive(0, 4'h0, 1, 0, 4'h0, 0, 0);
        check("drain_empty", 4'(exp_q.size()), 4'd0);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
